// File: rtl/lbm_pingpong_bank.sv
// Double-buffered LBM distribution store: N_CH channels, each with a read and a write bank of DEPTH words.
// Registered read (1 cycle), same-cycle write, swap takes effect next cycle; no backpressure, busy flags the init sweep.
module lbm_pingpong_bank #(
    parameter int N_CH       = 9,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2500,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         init_start,
    input  logic [N_CH*DATA_WIDTH-1:0]   init_vals,
    input  logic                         swap_req,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic [N_CH-1:0]              wr_en,
    input  logic [N_CH*ADDR_WIDTH-1:0]   wr_addr,
    input  logic [N_CH*DATA_WIDTH-1:0]   wr_data,
    output logic [N_CH*DATA_WIDTH-1:0]   rd_data,
    output logic                         rd_valid,
    output logic                         busy,
    output logic                         init_done,
    output logic                         swap_ack,
    output logic                         bank_sel,
    output logic [31:0]                  step_count,
    output logic                         err_oob
);

    typedef enum logic {IDLE, INIT} state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   sweep_addr;
    logic [DATA_WIDTH-1:0]   mem_a [N_CH][DEPTH];
    logic [DATA_WIDTH-1:0]   mem_b [N_CH][DEPTH];

    logic                    idle_op;
    logic                    rd_oob;
    logic [N_CH-1:0]         wr_oob;
    logic [N_CH-1:0]         wr_ok;

    // A cycle carrying init_start belongs to the sweep: its reads, writes and swap are discarded.
    always_comb begin
        idle_op = (state == IDLE) && !init_start;
        rd_oob  = ({1'b0, rd_addr} >= DEPTH_X);
        wr_oob  = '0;
        wr_ok   = '0;
        for (int k = 0; k < N_CH; k++) begin
            wr_oob[k] = ({1'b0, wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]} >= DEPTH_X);
            wr_ok[k]  = idle_op && wr_en[k] && !wr_oob[k];
        end
    end

    // Storage has no reset; bank_sel=0 means writes go to bank B.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (state == INIT) begin
                mem_a[k][sweep_addr] <= init_vals[k*DATA_WIDTH +: DATA_WIDTH];
                mem_b[k][sweep_addr] <= init_vals[k*DATA_WIDTH +: DATA_WIDTH];
            end else if (wr_ok[k]) begin
                if (bank_sel)
                    mem_a[k][wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                else
                    mem_b[k][wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sweep_addr <= '0;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            swap_ack   <= 1'b0;
            bank_sel   <= 1'b0;
            step_count <= '0;
            err_oob    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            init_done <= 1'b0;
            swap_ack  <= 1'b0;
            rd_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_start) begin
                        state      <= INIT;
                        busy       <= 1'b1;
                        sweep_addr <= '0;
                        bank_sel   <= 1'b0;
                        step_count <= '0;
                        err_oob    <= 1'b0;
                    end else begin
                        if (rd_en) begin
                            rd_valid <= 1'b1;
                            for (int k = 0; k < N_CH; k++) begin
                                if (rd_oob)
                                    rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= {DATA_WIDTH{1'b0}};
                                else if (bank_sel)
                                    rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= mem_b[k][rd_addr];
                                else
                                    rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= mem_a[k][rd_addr];
                            end
                        end
                        if ((rd_en && rd_oob) || (|(wr_en & wr_oob)))
                            err_oob <= 1'b1;
                        if (swap_req) begin
                            bank_sel   <= !bank_sel;
                            swap_ack   <= 1'b1;
                            step_count <= step_count + 32'd1;
                        end
                    end
                end
                INIT: begin
                    if (sweep_addr == LAST_ADDR) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lbm_pingpong_bank.sv
// Bench for lbm_pingpong_bank: directed vector table, init/reset sequences and randomized traffic against a bank model.
module tb_lbm_pingpong_bank;

    localparam int NC = 9;
    localparam int DW = 16;
    localparam int DP = 2500;
    localparam int AW = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic                init_start;
    logic [NC*DW-1:0]    init_vals;
    logic                swap_req;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [NC-1:0]       wr_en;
    logic [NC*AW-1:0]    wr_addr;
    logic [NC*DW-1:0]    wr_data;
    logic [NC*DW-1:0]    rd_data;
    logic                rd_valid;
    logic                busy;
    logic                init_done;
    logic                swap_ack;
    logic                bank_sel;
    logic [31:0]         step_count;
    logic                err_oob;

    lbm_pingpong_bank #(.N_CH(NC), .DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .init_start(init_start), .init_vals(init_vals),
        .swap_req(swap_req), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .init_done(init_done), .swap_ack(swap_ack), .bank_sel(bank_sel),
        .step_count(step_count), .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: two physical banks, mb names the one currently being read.
    logic [DW-1:0]    mm [2][NC][DP];
    logic             mb;
    logic [31:0]      msteps;
    logic             merr;
    logic [NC*DW-1:0] mrd;

    typedef struct {
        logic        sr;
        logic        re;
        logic [11:0] ra;
        int          c0;
        logic [11:0] a0;
        logic [15:0] d0;
        int          c1;
        logic [11:0] a1;
        logic [15:0] d1;
        logic        ev;
        logic        ea;
        logic        es;
        logic [31:0] en;
        logic        ee;
        int          cc;
        logic [15:0] cd;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        init_start = 1'b0;
        swap_req   = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
    endtask

    function automatic logic [AW-1:0] raddr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return AW'($urandom_range(DP, 4095));
        if (r < 3)  return AW'(DP - 1);
        return AW'($urandom_range(0, 15));
    endfunction

    task automatic step(input logic sr, input logic re, input logic [AW-1:0] ra,
                        input logic [NC-1:0] we, input logic [NC*AW-1:0] wa, input logic [NC*DW-1:0] wd);
        logic          ack;
        logic [AW-1:0] a;
        @(negedge clk);
        clr();
        swap_req = sr; rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
        if (re) begin
            for (int k = 0; k < NC; k++)
                mrd[k*DW +: DW] = (int'(ra) < DP) ? mm[mb][k][ra] : 16'h0;
            if (int'(ra) >= DP) merr = 1'b1;
        end
        for (int k = 0; k < NC; k++) begin
            if (we[k]) begin
                a = wa[k*AW +: AW];
                if (int'(a) < DP) mm[!mb][k][a] = wd[k*DW +: DW];
                else merr = 1'b1;
            end
        end
        ack = sr;
        if (sr) begin
            mb = !mb;
            msteps = msteps + 32'd1;
        end
        @(posedge clk); #1;
        chk("rd_valid", 144'(rd_valid), 144'(re));
        chk("rd_data", 144'(rd_data), 144'(mrd));
        chk("swap_ack", 144'(swap_ack), 144'(ack));
        chk("bank_sel", 144'(bank_sel), 144'(mb));
        chk("step_count", 144'(step_count), 144'(msteps));
        chk("err_oob", 144'(err_oob), 144'(merr));
        chk("busy_idle", 144'(busy), 144'(1'b0));
        chk("init_done_idle", 144'(init_done), 144'(1'b0));
    endtask

    task automatic rand_steps(input int n);
        logic            sr, re;
        logic [NC-1:0]   we;
        logic [NC*AW-1:0] wa;
        logic [NC*DW-1:0] wd;
        for (int i = 0; i < n; i++) begin
            sr = ($urandom_range(0, 3) == 0);
            re = 1'($urandom_range(0, 1));
            we = NC'($urandom);
            for (int k = 0; k < NC; k++) begin
                wa[k*AW +: AW] = ($urandom_range(0, 31) == 0) ? AW'($urandom_range(DP, 4095))
                                                               : AW'($urandom_range(0, 15));
                wd[k*DW +: DW] = DW'($urandom);
            end
            step(sr, re, raddr(), we, wa, wd);
        end
    endtask

    // Full init sweep with junk traffic on every sweep cycle; init_vals must already be set.
    task automatic do_init(input logic with_swap);
        int n;
        @(negedge clk);
        clr();
        init_start = 1'b1;
        swap_req   = with_swap;
        @(posedge clk); #1;
        chk("init_busy_rise", 144'(busy), 144'(1'b1));
        chk("init_no_ack", 144'(swap_ack), 144'(1'b0));
        chk("init_bank_sel", 144'(bank_sel), 144'(1'b0));
        chk("init_step_clr", 144'(step_count), 144'(32'd0));
        chk("init_err_clr", 144'(err_oob), 144'(1'b0));
        chk("init_rd_valid", 144'(rd_valid), 144'(1'b0));
        n = 1;
        for (int c = 0; c < DP + 20 && busy; c++) begin
            @(negedge clk);
            init_start = 1'($urandom);
            swap_req   = 1'($urandom);
            rd_en      = 1'b1;
            rd_addr    = raddr();
            wr_en      = NC'($urandom);
            for (int k = 0; k < NC; k++) begin
                wr_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
                wr_data[k*DW +: DW] = DW'($urandom);
            end
            @(posedge clk); #1;
            if (busy) n++;
            chk("sweep_rd_valid", 144'(rd_valid), 144'(1'b0));
            chk("sweep_swap_ack", 144'(swap_ack), 144'(1'b0));
        end
        chk("init_timeout", 144'(busy), 144'(1'b0));
        chk("init_busy_len", 144'(n), 144'(DP));
        chk("init_done_pulse", 144'(init_done), 144'(1'b1));
        chk("init_hold_rd", 144'(rd_data), 144'(mrd));
        @(negedge clk);
        clr();
        @(posedge clk); #1;
        chk("init_done_clear", 144'(init_done), 144'(1'b0));
        chk("init_after_valid", 144'(rd_valid), 144'(1'b0));
        for (int k = 0; k < NC; k++)
            for (int a = 0; a < DP; a++) begin
                mm[0][k][a] = init_vals[k*DW +: DW];
                mm[1][k][a] = init_vals[k*DW +: DW];
            end
        mb = 1'b0;
        msteps = '0;
        merr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC-1:0]    we;
        logic [NC*AW-1:0] wa;
        logic [NC*DW-1:0] wd;
        vec_t             v;

        tbl[0]  = '{1'b0, 1'b1, 12'd0,    -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 5, 16'h0105};
        tbl[1]  = '{1'b0, 1'b1, 12'd2499, -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8, 16'h0108};
        tbl[2]  = '{1'b0, 1'b0, 12'd0,     3, 12'd7, 16'h1234, -1, 12'd0, 16'h0,    1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 8, 16'h0108};
        tbl[3]  = '{1'b1, 1'b0, 12'd0,    -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b0, 1'b1, 1'b1, 32'd1, 1'b0, -1, 16'h0};
        tbl[4]  = '{1'b0, 1'b1, 12'd7,    -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b1, 1'b0, 1'b1, 32'd1, 1'b0, 3, 16'h1234};
        tbl[5]  = '{1'b0, 1'b1, 12'd7,    -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b1, 1'b0, 1'b1, 32'd1, 1'b0, 4, 16'h0104};
        tbl[6]  = '{1'b0, 1'b1, 12'd0,    -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b1, 1'b0, 1'b1, 32'd1, 1'b0, 0, 16'h0100};
        tbl[7]  = '{1'b0, 1'b1, 12'd2499, -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b1, 1'b0, 1'b1, 32'd1, 1'b0, 7, 16'h0107};
        tbl[8]  = '{1'b1, 1'b0, 12'd0,     0, 12'd5, 16'hBEEF, -1, 12'd0, 16'h0,    1'b0, 1'b1, 1'b0, 32'd2, 1'b0, -1, 16'h0};
        tbl[9]  = '{1'b0, 1'b1, 12'd5,    -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b1, 1'b0, 1'b0, 32'd2, 1'b0, 0, 16'hBEEF};
        tbl[10] = '{1'b0, 1'b0, 12'd0,     2, 12'd2500, 16'hDEAD, 4, 12'd9, 16'h4444, 1'b0, 1'b0, 1'b0, 32'd2, 1'b1, -1, 16'h0};
        tbl[11] = '{1'b1, 1'b0, 12'd0,    -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b0, 1'b1, 1'b1, 32'd3, 1'b1, -1, 16'h0};
        tbl[12] = '{1'b0, 1'b1, 12'd9,    -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 4, 16'h4444};
        tbl[13] = '{1'b0, 1'b1, 12'd9,    -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 2, 16'h0102};
        tbl[14] = '{1'b0, 1'b1, 12'd4095, -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 3, 16'h0};
        tbl[15] = '{1'b0, 1'b0, 12'd0,    -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b0, 1'b0, 1'b1, 32'd3, 1'b1, 3, 16'h0};
        tbl[16] = '{1'b1, 1'b0, 12'd0,    -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b0, 1'b1, 1'b0, 32'd4, 1'b1, -1, 16'h0};
        tbl[17] = '{1'b1, 1'b0, 12'd0,    -1, 12'd0, 16'h0,    -1, 12'd0, 16'h0,    1'b0, 1'b1, 1'b1, 32'd5, 1'b1, -1, 16'h0};

        rst = 1'b0;
        clr();
        init_vals = '0;
        mb = 1'b0; msteps = '0; merr = 1'b0; mrd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_data", 144'(rd_data), 144'(0));
        chk("rst_rd_valid", 144'(rd_valid), 144'(1'b0));
        chk("rst_busy", 144'(busy), 144'(1'b0));
        chk("rst_init_done", 144'(init_done), 144'(1'b0));
        chk("rst_swap_ack", 144'(swap_ack), 144'(1'b0));
        chk("rst_bank_sel", 144'(bank_sel), 144'(1'b0));
        chk("rst_step_count", 144'(step_count), 144'(32'd0));
        chk("rst_err_oob", 144'(err_oob), 144'(1'b0));
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < NC; k++) init_vals[k*DW +: DW] = 16'h0100 + 16'(k);
        do_init(1'b0);

        for (int i = 0; i < 18; i++) begin
            v = tbl[i];
            we = '0; wa = '0; wd = '0;
            if (v.c0 >= 0) begin
                we[v.c0] = 1'b1; wa[v.c0*AW +: AW] = v.a0; wd[v.c0*DW +: DW] = v.d0;
            end
            if (v.c1 >= 0) begin
                we[v.c1] = 1'b1; wa[v.c1*AW +: AW] = v.a1; wd[v.c1*DW +: DW] = v.d1;
            end
            step(v.sr, v.re, v.ra, we, wa, wd);
            chk($sformatf("row%0d_valid", i), 144'(rd_valid), 144'(v.ev));
            chk($sformatf("row%0d_ack", i), 144'(swap_ack), 144'(v.ea));
            chk($sformatf("row%0d_sel", i), 144'(bank_sel), 144'(v.es));
            chk($sformatf("row%0d_steps", i), 144'(step_count), 144'(v.en));
            chk($sformatf("row%0d_err", i), 144'(err_oob), 144'(v.ee));
            if (v.cc >= 0)
                chk($sformatf("row%0d_data", i), 144'(rd_data[v.cc*DW +: DW]), 144'(v.cd));
        end

        // bank_sel is 1 and err_oob set here: init must win over the same-cycle swap and clear both.
        for (int k = 0; k < NC; k++) init_vals[k*DW +: DW] = DW'($urandom);
        do_init(1'b1);
        rand_steps(300);

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        clr();
        init_start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        clr();
        repeat (1000) @(posedge clk);
        #2;
        chk("mid_busy_before", 144'(busy), 144'(1'b1));
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 144'(busy), 144'(1'b0));
        chk("mid_rst_bank_sel", 144'(bank_sel), 144'(1'b0));
        chk("mid_rst_step_count", 144'(step_count), 144'(32'd0));
        chk("mid_rst_rd_data", 144'(rd_data), 144'(0));
        chk("mid_rst_err", 144'(err_oob), 144'(1'b0));
        @(negedge clk);
        rst = 1'b1;
        mb = 1'b0; msteps = '0; merr = 1'b0; mrd = '0;

        for (int k = 0; k < NC; k++) init_vals[k*DW +: DW] = DW'($urandom);
        do_init(1'b0);
        rand_steps(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lbm_pingpong_bank.md
Name: lbm_pingpong_bank

Overview:
- Parametrised double-buffered distribution-function store for the LBM solver.
- Holds N_CH lattice directions, each with a read bank and a write bank of DEPTH words (2*N_CH memories in total).
- Adds an init sweep, a swap handshake with step counting, per-channel write enables, and out-of-range detection.
- Sits between the LBM controller and on-chip RAM, replacing the hand-instantiated fixed 9-direction RAM pairs.

Parameters:
- N_CH, 9, number of lattice directions (channels).
- DATA_WIDTH, 16, bits per distribution value (signed fixed point).
- DEPTH, 2500, lattice sites per channel.
- ADDR_WIDTH, 12, address bits; must satisfy 2^ADDR_WIDTH >= DEPTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- init_start  in  1  pulse: begin init sweep.
- init_vals  in  N_CH*DATA_WIDTH  per-channel init value; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- swap_req  in  1  pulse: exchange read/write banks.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_WIDTH  read address, shared by all channels.
- wr_en  in  N_CH  per-channel write enable.
- wr_addr  in  N_CH*ADDR_WIDTH  per-channel write address (streamed destinations differ per direction).
- wr_data  in  N_CH*DATA_WIDTH  per-channel write data.
- rd_data  out  N_CH*DATA_WIDTH  registered read data.
- rd_valid  out  1  rd_data is valid this cycle.
- busy  out  1  init sweep in progress.
- init_done  out  1  one-cycle pulse at the end of the sweep.
- swap_ack  out  1  one-cycle pulse when a swap is accepted.
- bank_sel  out  1  0: read A / write B; 1: read B / write A.
- step_count  out  32  number of accepted swaps since reset or init.
- err_oob  out  1  sticky flag: an out-of-range access occurred.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, busy=0, init_done=0, swap_ack=0, bank_sel=0, step_count=0, err_oob=0, FSM=IDLE, sweep counter=0. Memory contents are not reset.
- FSM has two states, IDLE and INIT.
- IDLE -> INIT on init_start. Init has priority: a swap_req in the same cycle is dropped and no swap_ack is given.
- INIT:
  - One address per cycle, addresses 0..DEPTH-1.
  - Writes init_vals[k] to both banks of every channel.
  - busy=1 from the cycle after init_start through the cycle of the address DEPTH-1 write.
  - init_done pulses the next cycle, and the FSM returns to IDLE.
  - Total sweep: DEPTH cycles.
  - init_vals is sampled each cycle and must be held stable by the driver.
- Entering INIT clears bank_sel, step_count and err_oob.
- During INIT: rd_en, wr_en, swap_req and init_start are ignored; rd_valid stays 0.
- Read (IDLE only):
  - rd_en at cycle t gives rd_data and rd_valid=1 at t+1, from the read bank selected by bank_sel at cycle t.
  - rd_valid is 0 on any cycle not following an accepted read.
  - rd_data holds its last value when no read is accepted.
  - rd_addr >= DEPTH: rd_data=0, rd_valid=1, err_oob set.
- Write (IDLE only):
  - For each k with wr_en[k]=1, wr_data[k] is written to wr_addr[k] in the current write bank, in the same cycle. Channels are independent.
  - wr_addr[k] >= DEPTH: that channel's write is dropped, err_oob set; other channels still write.
- Swap (IDLE only):
  - swap_req at cycle t: bank_sel toggles at t+1, swap_ack=1 at t+1, step_count increments at t+1.
  - step_count wraps 2^32-1 -> 0.
  - Reads and writes in cycle t use the pre-swap banks.
  - Back-to-back swap_req on consecutive cycles is accepted each cycle.
- Read-during-write to the same physical word cannot occur: the read and write banks are always distinct.
- Reset asserted mid-sweep aborts the sweep: FSM=IDLE, outputs return to reset values, partially initialised memory is left as-is.
- err_oob clears only on reset or on entering INIT.

Test Plan:
- Init: N_CH=9, init_vals channel k = 16'h0100+k, pulse init_start -> busy=1 for exactly 2500 cycles, then init_done one pulse. Reads of addr 0 and 2499 return 16'h0100+k on channel k both before and after one swap.
- Write/swap/read: write 16'h1234 to addr 7 on channel 3 only, then swap_req -> swap_ack one cycle later, bank_sel=1, step_count=1. Read addr 7 the next cycle -> channel 3 = 16'h1234, other channels keep their init value, rd_valid high exactly one cycle after rd_en.
- Same-cycle swap and write: swap_req with wr_en[0]=1, addr 5, data 16'hBEEF -> the data lands in the pre-swap write bank and is readable immediately after the swap.
- Out of range: wr_addr[2]=2500 with wr_en[2]=1 plus a valid write on channel 4 -> channel 2 write dropped, channel 4 written, err_oob=1. rd_addr=4095 -> rd_data=0, rd_valid=1. A subsequent init clears err_oob.
- Priority and ignore rules: init_start and swap_req in the same cycle -> no swap_ack, bank_sel=0. swap_req and rd_en during INIT -> ignored, rd_valid=0.
- Reset: drive rst=0 asynchronously mid-sweep at address 1000 -> busy=0, bank_sel=0, step_count=0 immediately, without waiting for a clock edge. After release, a new init completes normally.
